tlut_result_drain: RTL and testbench
====================================

TLUT_RESULT_DRAIN -- requirements
Module: tlut_result_drain

Interface
REQ-001 Parameter NUM_OUT, default 4, SHALL set the number of result words per pass (DIM_ROW1*DIM_COL2 of the upstream SIMD cell).
REQ-002 Parameter ACC_WIDTH, default 16, SHALL set the width of each result word.
REQ-003 Parameter CAP_DELAY, default 1, range 0..7, SHALL set the cycles from the finish pulse to the snapshot; it covers the registered adder-tree stage upstream.
REQ-004 One clock; reset is asynchronous and active-low. Ports: clk input 1 = clock; rst_n input 1 = asynchronous active-low reset.
REQ-005 finish  input  1  rollover pulse from the upstream SIMD cell; marks the end of an accumulation pass.
REQ-006 accumulated_mult  input  NUM_OUT x ACC_WIDTH  packed result matrix from the upstream SIMD cell; element 0 is in the LSBs.
REQ-007 clr_overrun  input  1  synchronous clear of the overrun flag.
REQ-008 out_data  output  ACC_WIDTH  serialized result word.
REQ-009 out_idx  output  clog2(NUM_OUT) (minimum 1)  element index of out_data.
REQ-010 out_valid  output  1  out_data/out_idx/out_last are valid.
REQ-011 out_ready  input  1  downstream accepts the word.
REQ-012 out_last  output  1  high with the final word of a pass.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 overrun  output  1  sticky flag: a finish pulse was dropped.

Function
REQ-015 The block SHALL use a three-state FSM: IDLE, WAIT, DRAIN.
REQ-016 IDLE: when finish=1, go to WAIT and load the delay counter with CAP_DELAY. If CAP_DELAY=0, instead snapshot accumulated_mult in that same cycle and go directly to DRAIN.
REQ-017 WAIT: decrement the delay counter each cycle. On the cycle the counter equals 1, snapshot all NUM_OUT words into the internal buffer and go to DRAIN.
REQ-018 The snapshot SHALL be the only write to the buffer. Changes on accumulated_mult after the snapshot SHALL NOT affect words being drained.
REQ-019 DRAIN: out_valid=1, out_data=buffer[idx], out_idx=idx; idx starts at 0.
REQ-020 A transfer SHALL occur on any clock edge where out_valid=1 and out_ready=1. On a transfer, idx increments by 1.
REQ-021 out_last SHALL equal out_valid AND (idx==NUM_OUT-1). A transfer while out_last=1 SHALL return the FSM to IDLE with idx=0.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable; no word is dropped or repeated.
REQ-023 out_valid SHALL NOT depend combinationally on out_ready.
REQ-024 out_data, out_idx and out_last SHALL be registered or driven from registered state only; no combinational path from accumulated_mult to outputs.
REQ-025 A finish pulse seen in WAIT or DRAIN SHALL be ignored for capture and SHALL set overrun=1.
REQ-026 A finish pulse in the same cycle as the final transfer (DRAIN to IDLE) SHALL count as an overrun. It SHALL NOT start a new pass.
REQ-027 overrun SHALL stay high until clr_overrun=1. If clr_overrun and a new overrun event occur in the same cycle, the set wins.
REQ-028 Minimum pass latency, with out_ready held high: first out_valid at CAP_DELAY+1 cycles after the finish edge; last transfer NUM_OUT-1 cycles later.
REQ-029 Throughput SHALL be one word per cycle under continuous out_ready.
REQ-030 busy SHALL equal (state != IDLE).

Reset
REQ-031 rst_n=0 SHALL asynchronously force: state=IDLE, idx=0, delay counter=0, out_valid=0, out_last=0, out_data=0, out_idx=0, busy=0, overrun=0. The buffer contents are don't-care.
REQ-032 Reset asserted mid-WAIT or mid-DRAIN SHALL abort the pass with no further out_valid. The first finish after rst_n deasserts SHALL start a clean pass.

Verification
REQ-033 Basic pass (CAP_DELAY=1, NUM_OUT=4): accumulated_mult={40,30,20,10}, finish pulse at cycle 0, out_ready=1 -> words 10,20,30,40 with idx 0..3 at cycles 2..5; out_last at cycle 5; busy low at cycle 6.
REQ-034 Backpressure: same pass with out_ready toggling 1,0,0,1,... -> each word held stable while stalled; exactly 4 transfers in order; no duplicates.
REQ-035 Snapshot isolation: change accumulated_mult to all 0xFFFF one cycle after the snapshot -> drained words remain 10,20,30,40.
REQ-036 Overrun: second finish pulse during DRAIN -> overrun=1, the current pass completes unchanged, no second pass. Then clr_overrun=1 -> overrun=0 on the next cycle.
REQ-037 Reset mid-DRAIN after 2 transfers: rst_n low for 1 cycle -> out_valid=0 immediately. A new finish then produces a full 4-word pass starting at idx 0.
REQ-038 CAP_DELAY=0 build: finish pulse -> out_valid at the next cycle, carrying the value present on accumulated_mult in the finish cycle.

Source files
------------

// File: rtl/tlut_result_drain_if.sv
// Result-drain bundle: upstream SIMD-cell inputs, serialized word stream, status.
// Latency: n/a (wires only).
// Backpressure: out_valid/out_ready handshake on the serialized stream.
interface tlut_result_drain_if #(
    parameter int NUM_OUT   = 4,
    parameter int ACC_WIDTH = 16,
    parameter int IDX_W     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
);
    logic                              finish;
    logic [NUM_OUT-1:0][ACC_WIDTH-1:0] accumulated_mult;
    logic                              clr_overrun;
    logic [ACC_WIDTH-1:0]              out_data;
    logic [IDX_W-1:0]                  out_idx;
    logic                              out_valid;
    logic                              out_ready;
    logic                              out_last;
    logic                              busy;
    logic                              overrun;

    // Drain side: consumes the result matrix, produces the word stream.
    modport master (
        input  finish, accumulated_mult, clr_overrun, out_ready,
        output out_data, out_idx, out_valid, out_last, busy, overrun
    );

    // Environment side: upstream cell plus downstream consumer.
    modport slave (
        output finish, accumulated_mult, clr_overrun, out_ready,
        input  out_data, out_idx, out_valid, out_last, busy, overrun
    );
endinterface

// File: rtl/tlut_result_drain.sv
// Snapshots the SIMD result matrix CAP_DELAY cycles after finish and serializes it word by word.
// Latency: first word CAP_DELAY+1 cycles after finish is sampled, then one word per cycle.
// Backpressure: words hold stable while out_ready=0; finish while busy is dropped and flagged as overrun.
module tlut_result_drain #(
    parameter int NUM_OUT   = 4,
    parameter int ACC_WIDTH = 16,
    parameter int CAP_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tlut_result_drain_if.master  bus
);
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                            state_q;
    state_t                            state_d;
    logic [2:0]                        cnt_q;
    logic [IDX_W-1:0]                  idx_q;
    logic [NUM_OUT-1:0][ACC_WIDTH-1:0] snap_q;
    logic                              overrun_q;

    logic                              snap_en;
    logic                              valid;
    logic                              last;
    logic                              xfer;
    logic [ACC_WIDTH-1:0]              data;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; the snapshot strobe is decided here because it coincides with entering DRAIN.
    always_comb begin
        state_d = state_q;
        snap_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.finish) begin
                    if (CAP_DELAY == 0) begin
                        snap_en = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // <= 1 rather than == 1 so a corrupted counter cannot park the FSM here.
                if (cnt_q <= 3'd1) begin
                    snap_en = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (xfer && last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only; data is zeroed outside DRAIN so reset shows 0.
    always_comb begin
        valid = (state_q == S_DRAIN);
        last  = valid && (idx_q == LAST_IDX);
        xfer  = valid && bus.out_ready;
        data  = valid ? snap_q[idx_q] : '0;
    end

    // Capture delay counter covering the upstream adder-tree register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 3'd0;
        end else if (state_q == S_IDLE && bus.finish) begin
            cnt_q <= 3'(CAP_DELAY);
        end else if (state_q == S_WAIT && cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    // Element index: advances per transfer, wraps to 0 on the final word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (xfer) begin
            idx_q <= last ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Result buffer: written only by the snapshot, so upstream changes during a drain are invisible.
    always_ff @(posedge clk) begin
        if (snap_en) begin
            snap_q <= bus.accumulated_mult;
        end
    end

    // Sticky overrun: any finish outside IDLE (including the final-transfer cycle); set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (bus.finish && state_q != S_IDLE) begin
            overrun_q <= 1'b1;
        end else if (bus.clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid;
    assign bus.out_last  = last;
    assign bus.out_idx   = idx_q;
    assign bus.out_data  = data;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_tlut_result_drain.sv
// Directed bench for tlut_result_drain: one CAP_DELAY=1 instance and one CAP_DELAY=0 instance.
// Latency: n/a.
// Backpressure: out_ready patterns driven per scenario.
module tb_tlut_result_drain;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tlut_result_drain_if #(.NUM_OUT(4), .ACC_WIDTH(16)) bus1 ();
    tlut_result_drain_if #(.NUM_OUT(4), .ACC_WIDTH(16)) bus0 ();

    tlut_result_drain #(.NUM_OUT(4), .ACC_WIDTH(16), .CAP_DELAY(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    tlut_result_drain #(.NUM_OUT(4), .ACC_WIDTH(16), .CAP_DELAY(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    localparam logic [63:0] MAT = {16'd40, 16'd30, 16'd20, 16'd10};

    // Advance to just after the next rising edge (start of the next cycle).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [21:0] got;
        rst_n = 1'b0;
        #2;
        got = {bus1.out_valid, bus1.out_last, bus1.out_idx, bus1.out_data, bus1.busy, bus1.overrun};
        n_cmp++;
        if (got !== 22'd0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h want=%h", got, 22'd0);
        end
        n_cmp++;
        if ({bus0.out_valid, bus0.busy, bus0.overrun} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_cap0 got=%b want=000", {bus0.out_valid, bus0.busy, bus0.overrun});
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [19:0] got, exp_v;
        bus1.accumulated_mult = MAT;
        bus1.out_ready = 1'b1;
        bus1.finish = 1'b1;
        tick();
        bus1.finish = 1'b0;
        n_cmp++;
        if ({bus1.out_valid, bus1.busy} !== 2'b01) begin
            n_err++;
            $display("FAIL basic_wait valid/busy got=%b want=01", {bus1.out_valid, bus1.busy});
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            got   = {bus1.out_valid, bus1.out_last, bus1.out_idx, bus1.out_data};
            exp_v = {1'b1, (k == 3), 2'(k), 16'(10 * (k + 1))};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL basic_word%0d got=%h want=%h", k, got, exp_v);
            end
            tick();
        end
        n_cmp++;
        if ({bus1.out_valid, bus1.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_done valid/busy got=%b want=00", {bus1.out_valid, bus1.busy});
        end
    endtask

    task automatic test_backpressure();
        logic [19:0] got, exp_v;
        int k;
        int cyc;
        bus1.accumulated_mult = MAT;
        bus1.out_ready = 1'b1;
        bus1.finish = 1'b1;
        tick();
        bus1.finish = 1'b0;
        tick();
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 30) begin
            bus1.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            got   = {bus1.out_valid, bus1.out_last, bus1.out_idx, bus1.out_data};
            exp_v = {1'b1, (k == 3), 2'(k), 16'(10 * (k + 1))};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL bp_word cyc=%0d k=%0d got=%h want=%h", cyc, k, got, exp_v);
            end
            tick();
            if (bus1.out_ready) k++;
            cyc++;
        end
        bus1.out_ready = 1'b1;
        n_cmp++;
        if (k !== 4) begin
            n_err++;
            $display("FAIL bp_count got=%0d want=4", k);
        end
        n_cmp++;
        if ({bus1.out_valid, bus1.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL bp_done valid/busy got=%b want=00", {bus1.out_valid, bus1.busy});
        end
    endtask

    task automatic test_isolation();
        logic [19:0] got, exp_v;
        bus1.out_ready = 1'b1;
        // Finish-cycle value is stale; the value at the end of WAIT is what gets captured.
        bus1.accumulated_mult = {16'd4, 16'd3, 16'd2, 16'd1};
        bus1.finish = 1'b1;
        tick();
        bus1.finish = 1'b0;
        bus1.accumulated_mult = MAT;
        tick();
        bus1.accumulated_mult = {4{16'hFFFF}};
        for (int k = 0; k < 4; k++) begin
            got   = {bus1.out_valid, bus1.out_last, bus1.out_idx, bus1.out_data};
            exp_v = {1'b1, (k == 3), 2'(k), 16'(10 * (k + 1))};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL iso_word%0d got=%h want=%h", k, got, exp_v);
            end
            tick();
        end
        bus1.accumulated_mult = MAT;
    endtask

    task automatic test_overrun();
        logic [19:0] got, exp_v;
        logic        seen_busy;
        bus1.accumulated_mult = MAT;
        bus1.out_ready = 1'b1;
        bus1.finish = 1'b1;
        tick();
        bus1.finish = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            got   = {bus1.out_valid, bus1.out_last, bus1.out_idx, bus1.out_data};
            exp_v = {1'b1, (k == 3), 2'(k), 16'(10 * (k + 1))};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL ovr_word%0d got=%h want=%h", k, got, exp_v);
            end
            bus1.finish = (k == 1);
            tick();
            bus1.finish = 1'b0;
            if (k == 1) begin
                n_cmp++;
                if (bus1.overrun !== 1'b1) begin
                    n_err++;
                    $display("FAIL ovr_set got=%b want=1", bus1.overrun);
                end
            end
        end
        seen_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen_busy |= bus1.busy | bus1.out_valid;
            tick();
        end
        n_cmp++;
        if (seen_busy !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_no_second_pass got=%b want=0", seen_busy);
        end
        bus1.clr_overrun = 1'b1;
        tick();
        bus1.clr_overrun = 1'b0;
        n_cmp++;
        if (bus1.overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clear got=%b want=0", bus1.overrun);
        end

        // Finish coinciding with the final transfer: overrun, no new pass.
        bus1.finish = 1'b1;
        tick();
        bus1.finish = 1'b0;
        tick();
        tick();
        tick();
        tick();
        n_cmp++;
        if ({bus1.out_last, bus1.out_idx} !== 3'b111) begin
            n_err++;
            $display("FAIL ovr_last_pos got=%b want=111", {bus1.out_last, bus1.out_idx});
        end
        bus1.finish = 1'b1;
        tick();
        bus1.finish = 1'b0;
        n_cmp++;
        if ({bus1.overrun, bus1.busy} !== 2'b10) begin
            n_err++;
            $display("FAIL ovr_final_xfer overrun/busy got=%b want=10", {bus1.overrun, bus1.busy});
        end
        tick();
        tick();
        n_cmp++;
        if ({bus1.busy, bus1.out_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL ovr_final_no_pass got=%b want=00", {bus1.busy, bus1.out_valid});
        end

        // Clear and new overrun event in the same cycle: set wins.
        bus1.clr_overrun = 1'b1;
        tick();
        bus1.clr_overrun = 1'b0;
        bus1.finish = 1'b1;
        tick();
        bus1.finish = 1'b1;
        bus1.clr_overrun = 1'b1;
        tick();
        bus1.finish = 1'b0;
        bus1.clr_overrun = 1'b0;
        n_cmp++;
        if (bus1.overrun !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_set_wins got=%b want=1", bus1.overrun);
        end
        for (int i = 0; i < 5; i++) tick();
        bus1.clr_overrun = 1'b1;
        tick();
        bus1.clr_overrun = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [19:0] got, exp_v;
        bus1.accumulated_mult = MAT;
        bus1.out_ready = 1'b1;
        bus1.finish = 1'b1;
        tick();
        bus1.finish = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus1.out_valid, bus1.busy, bus1.out_idx} !== 4'b0000) begin
            n_err++;
            $display("FAIL rstmid_abort got=%b want=0000", {bus1.out_valid, bus1.busy, bus1.out_idx});
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus1.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_quiet got=%b want=0", bus1.out_valid);
        end
        bus1.finish = 1'b1;
        tick();
        bus1.finish = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            got   = {bus1.out_valid, bus1.out_last, bus1.out_idx, bus1.out_data};
            exp_v = {1'b1, (k == 3), 2'(k), 16'(10 * (k + 1))};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL rstmid_word%0d got=%h want=%h", k, got, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_cap0();
        logic [19:0] got, exp_v;
        bus0.out_ready = 1'b1;
        bus0.accumulated_mult = {16'd4, 16'd3, 16'd2, 16'd1};
        bus0.finish = 1'b1;
        tick();
        bus0.finish = 1'b0;
        bus0.accumulated_mult = {4{16'hFFFF}};
        for (int k = 0; k < 4; k++) begin
            got   = {bus0.out_valid, bus0.out_last, bus0.out_idx, bus0.out_data};
            exp_v = {1'b1, (k == 3), 2'(k), 16'(k + 1)};
            n_cmp++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL cap0_word%0d got=%h want=%h", k, got, exp_v);
            end
            tick();
        end
        n_cmp++;
        if ({bus0.out_valid, bus0.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL cap0_done got=%b want=00", {bus0.out_valid, bus0.busy});
        end
    endtask

    initial begin
        bus1.finish = 1'b0;
        bus1.accumulated_mult = '0;
        bus1.clr_overrun = 1'b0;
        bus1.out_ready = 1'b1;
        bus0.finish = 1'b0;
        bus0.accumulated_mult = '0;
        bus0.clr_overrun = 1'b0;
        bus0.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_isolation();
        test_overrun();
        test_reset_mid();
        test_cap0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
